parking_gate: RTL and testbench
===============================

# parking_gate

Lane controller for the parking lot, on the requesting side of the occupancy FSM's enter/exit interface. It has two lanes, entry and exit. For each lane it synchronises and debounces a raw vehicle-presence sensor and issues single-cycle `enter`/`exit` request pulses to the occupancy FSM. It then samples that FSM's same-cycle `open_door`/`full` responses and drives the barrier and lamp outputs.

## Interface
- `DEB_CYCLES`, default 4: consecutive synchronised-high cycles required to qualify a sensor.
- `HOLD_CYCLES`, default 8: consecutive sensor-low cycles after the vehicle passes before the barrier closes.
- `TIMEOUT_CYCLES`, default 256: maximum cycles a barrier may stay open (only with `PARKING_GATE_TIMEOUT_EN`).
- `CLK` input, 1 bit: the single clock, rising edge.
- `RST` input, 1 bit: asynchronous, active-low reset.
- `in_sensor` input, 1 bit: raw entry-lane presence sensor, asynchronous.
- `out_sensor` input, 1 bit: raw exit-lane presence sensor, asynchronous.
- `open_door` input, 1 bit: grant from the occupancy FSM, combinational on `enter`/`exit`.
- `full` input, 1 bit: lot-full response from the occupancy FSM, combinational on `enter`.
- `enter` output, 1 bit: entry request pulse to the occupancy FSM.
- `exit` output, 1 bit: exit request pulse to the occupancy FSM.
- `entry_barrier` output, 1 bit: raises the entry barrier when 1.
- `exit_barrier` output, 1 bit: raises the exit barrier when 1.
- `full_lamp` output, 1 bit: "lot full" sign at the entry lane.
- `fault` output, 1 bit: sticky barrier-timeout flag (tied to 0 without the macro).

## Operation
- Each raw sensor passes through a 2-flop synchroniser. All further logic uses the synchronised value `s`.
- Per-lane Moore FSM, `IDLE -> DEB -> REQ -> PULSE -> OPEN | DENIED -> IDLE`:
  - **IDLE**: barrier 0. If `s`=1, go to DEB and clear the counter.
  - **DEB**: the counter increments while `s`=1. If `s`=0, return to IDLE. When the counter reaches `DEB_CYCLES`-1 with `s`=1, go to REQ.
  - **REQ**: wait for an arbiter grant, then go to PULSE.
  - **PULSE**: the lane's `enter`/`exit` is 1 for exactly this cycle. At the closing edge, sample `open_door`:
    - `open_door`=1: go to OPEN.
    - `open_door`=0: go to DENIED.
    - Entry lane only: register `full_lamp` = `full`.
  - **OPEN**: barrier 1.
    - Wait for `s`=0, then count `HOLD_CYCLES` consecutive low cycles and go to IDLE.
    - If `s` rises during the hold, the counter clears and waiting restarts.
  - **DENIED**: barrier 0. Go to IDLE when `s`=0. `full_lamp` clears on the entry lane's exit from DENIED.
- Arbiter: at most one lane is in PULSE in any cycle, so `enter` and `exit` are never 1 together.
  - If both lanes are in REQ, the exit lane is granted first, because an exit frees capacity.
  - The entry lane is granted the following cycle at the earliest.
- An exit denial (lot empty, `open_door`=0) keeps the exit barrier down and leaves `full_lamp` untouched.
- Counters are sized with `$clog2` of their limit and saturate; they never wrap.
- Reset (asynchronous, any state): both lanes go to IDLE, synchronisers and counters clear, and all outputs are 0. A reset mid-OPEN drops the barrier immediately.

## Timing
- Sensor rise to `enter`/`exit` high, uncontended: 2 (sync) + `DEB_CYCLES` + 1 (REQ) + 1 cycles. The pulse is 1 cycle wide and registered.
- Barrier rises the cycle after PULSE. It falls `HOLD_CYCLES`+1 cycles after synchronised `s` falls (DENIED: 1 cycle after).
- `open_door`/`full` need to be valid only at the rising edge that ends PULSE.
- A contended entry request is delayed by exactly 1 cycle per exit grant.

## Configuration
- `PARKING_GATE_TIMEOUT_EN` defined:
  - A per-lane counter runs while the lane is in OPEN.
  - On reaching `TIMEOUT_CYCLES`, the lane forces IDLE (barrier 0) and sets `fault`.
  - `fault` clears only on `RST`.
- Undefined: no timeout counter, and `fault` is constant 0. OPEN persists until the hold completes.

## Structure
- Shared package `parking_pkg` holds:
  - the lane state encoding `IDLE`/`DEB`/`REQ`/`PULSE`/`OPEN`/`DENIED`;
  - default constants for `DEB_CYCLES`, `HOLD_CYCLES` and `TIMEOUT_CYCLES`.
- Sub-module `gate_lane` contains the synchroniser, debounce, FSM and counters, and is instantiated twice.
- `parking_gate` contains the two lanes, the fixed-priority arbiter and the `full_lamp`/`fault` registers.

## Test plan
- **Reset**: `RST`=0 mid-OPEN -> barrier, `enter`, `exit`, `full_lamp`, `fault` all 0 asynchronously; lane idle after release.
- **Glitch**: `in_sensor` high 3 cycles with `DEB_CYCLES`=4 -> no `enter` pulse.
- **Normal entry**: `in_sensor` held high, `open_door`=1 -> `enter` is a 1-cycle pulse at cycle 8 after the rise. `entry_barrier`=1 from cycle 9. It drops 9 cycles after the synchronised sensor falls.
- **Full lot**: `open_door`=0, `full`=1 during the pulse -> `entry_barrier` stays 0 and `full_lamp`=1 until `in_sensor` is low.
- **Simultaneous requests**: both sensors rise on the same cycle -> `exit` pulses at cycle N, `enter` at N+1; never both high.
- **Timeout** (macro on, `TIMEOUT_CYCLES`=16): sensor stuck high in OPEN -> barrier drops after 16 cycles and `fault`=1 until reset.

Source files
------------

// File: rtl/parking_gate_pkg.sv
// Shared lane state encoding and default timing constants for the parking gate
// lane controller.
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DEB    = 3'd1,
        REQ    = 3'd2,
        PULSE  = 3'd3,
        OPEN   = 3'd4,
        DENIED = 3'd5
    } lane_state_e;

    localparam int unsigned DEB_CYCLES_DEF     = 4;
    localparam int unsigned HOLD_CYCLES_DEF    = 8;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 256;

endpackage

// File: rtl/parking_gate_lane.sv
// One lane: 2-flop sensor synchroniser, debounce, request/open FSM and hold counter.
// Optional open-barrier timeout under PARKING_GATE_TIMEOUT_EN.
module gate_lane
    import parking_pkg::*;
#(
    parameter int unsigned DEB_CYCLES     = DEB_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES    = HOLD_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sensor_raw,
    input  logic grant,
    input  logic door_ok,
    output logic req,
    output logic pulse,
    output logic barrier,
    output logic deny_done,
    output logic timeout
);

    localparam int unsigned CNT_MAX = ((DEB_CYCLES - 1) > HOLD_CYCLES) ? (DEB_CYCLES - 1) : HOLD_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES);

    lane_state_e      state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s;
    logic             timeout_hit;

    assign sync_d = {sync_q[0], sensor_raw};
    assign s      = sync_q[1];

`ifdef PARKING_GATE_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] tmr_q, tmr_d;

    always_comb begin
        tmr_d = '0;
        if (state_q == OPEN && tmr_q != TMR_LAST) begin
            tmr_d = tmr_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

    assign timeout_hit = (state_q == OPEN) && (tmr_q == TMR_LAST);
`else
    localparam int unsigned UNUSED_TMO = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = DEB;
                    cnt_d   = '0;
                end
            end
            DEB: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = REQ;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REQ: begin
                if (grant) begin
                    state_d = PULSE;
                end
            end
            PULSE: begin
                state_d = door_ok ? OPEN : DENIED;
                cnt_d   = '0;
            end
            OPEN: begin
                // any presence restarts the hold; counter stops at HOLD_LAST
                if (s) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DENIED: begin
                if (!s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (timeout_hit) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sync_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req       = (state_q == REQ);
    assign pulse     = (state_q == PULSE);
    assign barrier   = (state_q == OPEN);
    assign deny_done = (state_q == DENIED) && !s;
    assign timeout   = timeout_hit;

endmodule

// File: rtl/parking_gate.sv
// Two-lane parking gate controller: entry/exit lanes, exit-first arbiter,
// full lamp and sticky fault (timeout enabled by PARKING_GATE_TIMEOUT_EN).
module parking_gate
    import parking_pkg::*;
#(
    parameter int unsigned DEB_CYCLES     = DEB_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES    = HOLD_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic in_sensor,
    input  logic out_sensor,
    input  logic open_door,
    input  logic full,
    output logic enter,
    output logic exit,
    output logic entry_barrier,
    output logic exit_barrier,
    output logic full_lamp,
    output logic fault
);

    logic entry_req, entry_pulse, entry_deny_done, entry_to;
    logic exit_req, exit_pulse, exit_deny_done, exit_to;
    logic entry_grant, exit_grant;
    logic full_lamp_q, full_lamp_d;

    // exit frees capacity, so it wins; entry follows once exit leaves REQ
    assign exit_grant  = exit_req;
    assign entry_grant = entry_req && !exit_req;

    gate_lane #(
        .DEB_CYCLES    (DEB_CYCLES),
        .HOLD_CYCLES   (HOLD_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_entry (
        .clk       (CLK),
        .rst_n     (RST),
        .sensor_raw(in_sensor),
        .grant     (entry_grant),
        .door_ok   (open_door),
        .req       (entry_req),
        .pulse     (entry_pulse),
        .barrier   (entry_barrier),
        .deny_done (entry_deny_done),
        .timeout   (entry_to)
    );

    gate_lane #(
        .DEB_CYCLES    (DEB_CYCLES),
        .HOLD_CYCLES   (HOLD_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_exit (
        .clk       (CLK),
        .rst_n     (RST),
        .sensor_raw(out_sensor),
        .grant     (exit_grant),
        .door_ok   (open_door),
        .req       (exit_req),
        .pulse     (exit_pulse),
        .barrier   (exit_barrier),
        .deny_done (exit_deny_done),
        .timeout   (exit_to)
    );

    assign enter = entry_pulse;
    assign exit  = exit_pulse;

    always_comb begin
        full_lamp_d = full_lamp_q;
        if (entry_pulse) begin
            full_lamp_d = full;
        end else if (entry_deny_done) begin
            full_lamp_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            full_lamp_q <= 1'b0;
        end else begin
            full_lamp_q <= full_lamp_d;
        end
    end

    assign full_lamp = full_lamp_q;

`ifdef PARKING_GATE_TIMEOUT_EN
    logic fault_q, fault_d;

    assign fault_d = fault_q | entry_to | exit_to;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    logic unused_lane_sigs;
    assign unused_lane_sigs = entry_to ^ exit_to ^ exit_deny_done;
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_parking_gate.sv
// Directed self-checking bench for parking_gate (DEB=4, HOLD=8, TIMEOUT=16);
// the timeout scenario runs only when PARKING_GATE_TIMEOUT_EN is defined.
module tb_parking_gate;

    logic CLK = 1'b0;
    logic RST;
    logic in_sensor, out_sensor, open_door, full;
    logic enter, exit, entry_barrier, exit_barrier, full_lamp, fault;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 CLK = ~CLK;

    parking_gate #(
        .DEB_CYCLES    (4),
        .HOLD_CYCLES   (8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .in_sensor    (in_sensor),
        .out_sensor   (out_sensor),
        .open_door    (open_door),
        .full         (full),
        .enter        (enter),
        .exit         (exit),
        .entry_barrier(entry_barrier),
        .exit_barrier (exit_barrier),
        .full_lamp    (full_lamp),
        .fault        (fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".enter"}, 32'(enter), 0);
        check({tag, ".exit"}, 32'(exit), 0);
        check({tag, ".entry_barrier"}, 32'(entry_barrier), 0);
        check({tag, ".exit_barrier"}, 32'(exit_barrier), 0);
        check({tag, ".full_lamp"}, 32'(full_lamp), 0);
        check({tag, ".fault"}, 32'(fault), 0);
    endtask

    initial begin
        logic seen;
        RST        = 1'b0;
        in_sensor  = 1'b0;
        out_sensor = 1'b0;
        open_door  = 1'b0;
        full       = 1'b0;
        #12;
        check_idle_outputs("reset");
        RST = 1'b1;
        tick(3);

        // glitch: 3 raw-high cycles never qualify
        in_sensor = 1'b1;
        tick(3);
        in_sensor = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            seen = seen | enter;
        end
        check("glitch.enter", 32'(seen), 0);

        // normal entry: pulse at cycle 8, barrier from 9, drops 9 after s falls
        open_door = 1'b1;
        in_sensor = 1'b1;
        tick(7);
        check("entry.pre_pulse", 32'(enter), 0);
        tick(1);
        check("entry.pulse", 32'(enter), 1);
        check("entry.barrier_during_pulse", 32'(entry_barrier), 0);
        tick(1);
        check("entry.pulse_end", 32'(enter), 0);
        check("entry.barrier_up", 32'(entry_barrier), 1);
        in_sensor = 1'b0;
        tick(10);
        check("entry.barrier_hold", 32'(entry_barrier), 1);
        tick(1);
        check("entry.barrier_down", 32'(entry_barrier), 0);
        tick(4);

        // full lot, then an exit denial that must not touch the lamp
        open_door = 1'b0;
        full      = 1'b1;
        in_sensor = 1'b1;
        tick(8);
        check("full.pulse", 32'(enter), 1);
        check("full.lamp_before", 32'(full_lamp), 0);
        tick(1);
        check("full.barrier", 32'(entry_barrier), 0);
        check("full.lamp", 32'(full_lamp), 1);
        out_sensor = 1'b1;
        tick(8);
        check("deny_exit.pulse", 32'(exit), 1);
        check("deny_exit.no_enter", 32'(enter), 0);
        tick(1);
        check("deny_exit.barrier", 32'(exit_barrier), 0);
        check("deny_exit.lamp_kept", 32'(full_lamp), 1);
        in_sensor  = 1'b0;
        out_sensor = 1'b0;
        tick(2);
        check("full.lamp_hold", 32'(full_lamp), 1);
        tick(1);
        check("full.lamp_clear", 32'(full_lamp), 0);
        tick(4);

        // simultaneous: exit at cycle 8, entry at 9
        open_door  = 1'b1;
        full       = 1'b0;
        in_sensor  = 1'b1;
        out_sensor = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick(1);
            check($sformatf("sim.enter[%0d]", c), 32'(enter), 32'(c == 9));
            check($sformatf("sim.exit[%0d]", c), 32'(exit), 32'(c == 8));
            check($sformatf("sim.exit_bar[%0d]", c), 32'(exit_barrier), 32'(c >= 9));
            check($sformatf("sim.entry_bar[%0d]", c), 32'(entry_barrier), 32'(c >= 10));
        end
        in_sensor  = 1'b0;
        out_sensor = 1'b0;
        tick(10);
        check("sim.entry_bar_hold", 32'(entry_barrier), 1);
        tick(1);
        check("sim.entry_bar_down", 32'(entry_barrier), 0);
        check("sim.exit_bar_down", 32'(exit_barrier), 0);
        tick(4);

        // reset mid-OPEN drops everything asynchronously
        in_sensor = 1'b1;
        tick(12);
        check("rst.barrier_open", 32'(entry_barrier), 1);
        #3;
        RST = 1'b0;
        #1;
        check_idle_outputs("rst_async");
        in_sensor = 1'b0;
        #2;
        RST = 1'b1;
        tick(1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            seen = seen | enter | entry_barrier;
        end
        check("rst.idle_after", 32'(seen), 0);
        in_sensor = 1'b1;
        tick(8);
        check("rst.fresh_pulse", 32'(enter), 1);
        in_sensor = 1'b0;
        tick(14);
        check("rst.fresh_closed", 32'(entry_barrier), 0);

`ifdef PARKING_GATE_TIMEOUT_EN
        // stuck sensor: barrier forced down after 16 open cycles, fault sticks
        open_door = 1'b1;
        in_sensor = 1'b1;
        tick(24);
        check("tmo.barrier_open", 32'(entry_barrier), 1);
        check("tmo.fault_before", 32'(fault), 0);
        tick(1);
        check("tmo.barrier_forced", 32'(entry_barrier), 0);
        check("tmo.fault_set", 32'(fault), 1);
        in_sensor = 1'b0;
        open_door = 1'b0;
        tick(6);
        check("tmo.fault_sticky", 32'(fault), 1);
        #3;
        RST = 1'b0;
        #1;
        check("tmo.fault_reset", 32'(fault), 0);
        #2;
        RST = 1'b1;
        tick(2);
`else
        check("nofault.fault", 32'(fault), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
